icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter ICACHE_IDX_W, default 4, log2 of line count (16 lines, one instruction per line).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; when low, all state and outputs SHALL hold.
REQ-005 flush  input  1  misprediction flush from ROB.
REQ-006 fet_req  input  1  fetcher request, valid one cycle, sampled only when ic_busy==0.
REQ-007 fet_pc  input  XLEN  halfword-aligned fetch PC.
REQ-008 ic_busy  output  1  combinational, high when state != IDLE.
REQ-009 ic_inst_valid  output  1  registered one-cycle pulse, instruction delivered.
REQ-010 ic_inst  output  XLEN  instruction word (compressed: upper 16 bits zero); 0 when ic_inst_valid==0.
REQ-011 ic_inst_addr  output  XLEN  PC of delivered instruction.
REQ-012 ic_mem_enable  output  1  fetch request to memory controller (drives fet_mem_enable).
REQ-013 ic_mem_pc  output  XLEN  miss PC to memory controller (drives fet_pc).
REQ-014 mem_fet_busy  input  1  memory controller busy with any operation.
REQ-015 mem_inst_ready, mem_inst, mem_inst_addr  input  1/XLEN/XLEN  memory controller instruction return.

Function
REQ-016 Lookup SHALL use index = pc[ICACHE_IDX_W:1], tag = pc[XLEN-1:ICACHE_IDX_W+1]; each line holds valid, tag, 32-bit word.
REQ-017 FSM states IDLE, MISS_REQ, MISS_WAIT; encoding local to module.
REQ-018 IDLE + fet_req + hit: next cycle ic_inst_valid=1, ic_inst=line word, ic_inst_addr=fet_pc; state stays IDLE (1-cycle latency, back-to-back hits allowed every cycle).
REQ-019 IDLE + fet_req + miss: latch miss_pc=fet_pc, state->MISS_REQ; no ic_inst_valid.
REQ-020 MISS_REQ: ic_mem_enable SHALL be high combinationally only while mem_fet_busy==0 and flush==0; on that cycle state->MISS_WAIT; otherwise remain in MISS_REQ; ic_mem_enable is never high outside MISS_REQ.
REQ-021 ic_mem_pc SHALL equal miss_pc at all times.
REQ-022 MISS_WAIT: on mem_inst_ready==1 and mem_inst_addr==miss_pc, write line (valid=1, tag, mem_inst), next cycle ic_inst_valid=1 with ic_inst=mem_inst, ic_inst_addr=miss_pc; state->IDLE.
REQ-023 mem_inst_ready with mismatched address, or in IDLE/MISS_REQ, SHALL be ignored.
REQ-024 Fill overwrites the indexed line unconditionally (direct-mapped, no replacement choice).
REQ-025 flush in any state: state->IDLE, ic_inst_valid<=0, fet_req same cycle ignored, valid bits retained; flush overrides a simultaneous fill (no line write).
REQ-026 A request whose fill arrives in the same cycle as a lookup to that index is impossible (busy); no bypass path required.
REQ-027 ic_inst_valid SHALL never be high two cycles for the same miss.

Reset
REQ-028 On rst: state=IDLE, all valid bits 0, ic_inst_valid=0, ic_inst_addr=0, miss_pc=0, ic_mem_enable=0.
REQ-029 rst overrides flush and rdy==1 requirement not waived: rst takes effect only when rdy==1.
REQ-030 rst mid-miss SHALL abandon the miss without writing any line.

Structure
REQ-031 ICACHE_IDX_W default and XLEN SHALL live in global_params.v; FSM encodings are module-local localparams.
REQ-032 Tag/data/valid arrays are inline register arrays; no sub-module.

Verification
REQ-033 Cold miss: rst, fet_req pc=0x0000_1000 -> MISS_REQ, ic_mem_enable with ic_mem_pc=0x1000, return 0x00500093 -> ic_inst_valid with ic_inst=0x00500093, addr=0x1000.
REQ-034 Hit: repeat pc=0x1000 -> ic_inst_valid next cycle, ic_mem_enable stays 0; four consecutive hits at 0x1000/0x1004/0x1008/0x100C (pre-filled) -> four consecutive valid pulses.
REQ-035 Conflict: fill 0x1000 then 0x1020 (same index) -> 0x1000 misses again.
REQ-036 Memory busy: mem_fet_busy=1 for 5 cycles during MISS_REQ -> ic_mem_enable held 0, asserted the cycle busy drops.
REQ-037 Flush in MISS_WAIT, late return for miss_pc -> no ic_inst_valid, line stays invalid, ic_busy=0 next cycle.
REQ-038 Compressed: pc=0x1002 returns 0x00004501 -> ic_inst=0x00004501, distinct line from 0x1000.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths for the instruction cache
// Purpose: global machine width and default cache geometry, imported by icache.
// Ports: none (package).
package icache_pkg;

  // Machine word / address width.
  localparam int XLEN = 32;

  // Default log2 of the line count (one instruction per line).
  localparam int ICACHE_IDX_W_DEFAULT = 4;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache, one instruction per line
// Purpose: serves fetcher requests from a small direct-mapped array, hitting
//   with one-cycle latency and refilling a missed line from the memory
//   controller. Lines are indexed by halfword so compressed instructions at
//   pc+2 occupy their own line.
// Ports:
//   clk            system clock, all state updates on posedge
//   rst            synchronous active-high reset, effective only while rdy=1
//   rdy            global enable; when low all state and outputs hold
//   flush          misprediction flush, aborts any request or miss
//   fet_req/fet_pc fetch request and halfword-aligned PC (sampled when idle)
//   ic_busy        high whenever a miss is outstanding
//   ic_inst_valid  one-cycle delivery pulse, with ic_inst / ic_inst_addr
//   ic_mem_enable  miss request to memory controller, ic_mem_pc its address
//   mem_fet_busy   memory controller busy, request is held off
//   mem_inst_*     memory controller instruction return
module icache
  import icache_pkg::*;
#(
  parameter int ICACHE_IDX_W = ICACHE_IDX_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            fet_req,
  input  logic [XLEN-1:0] fet_pc,
  output logic            ic_busy,
  output logic            ic_inst_valid,
  output logic [XLEN-1:0] ic_inst,
  output logic [XLEN-1:0] ic_inst_addr,
  output logic            ic_mem_enable,
  output logic [XLEN-1:0] ic_mem_pc,
  input  logic            mem_fet_busy,
  input  logic            mem_inst_ready,
  input  logic [XLEN-1:0] mem_inst,
  input  logic [XLEN-1:0] mem_inst_addr
);

  localparam int NLINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W  = XLEN - ICACHE_IDX_W - 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MISS_REQ  = 2'd1,
    S_MISS_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   miss_pc_q, miss_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   inst_addr_q, inst_addr_d;
  logic              fill_en;

  // Line storage: valid bits are reset, tag/data are not.
  logic [NLINES-1:0] line_valid_q;
  logic [TAG_W-1:0]  line_tag_q  [NLINES];
  logic [XLEN-1:0]   line_data_q [NLINES];

  logic [ICACHE_IDX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0]        req_tag, miss_tag;
  logic                    req_hit;
  logic                    fill_match;
  logic                    unused_pc_lsb;

  // Index skips bit 0: every halfword address gets its own line.
  assign req_idx  = fet_pc[ICACHE_IDX_W:1];
  assign req_tag  = fet_pc[XLEN-1:ICACHE_IDX_W+1];
  assign miss_idx = miss_pc_q[ICACHE_IDX_W:1];
  assign miss_tag = miss_pc_q[XLEN-1:ICACHE_IDX_W+1];

  // Aligned PCs never set bit 0, so it takes no part in the lookup.
  assign unused_pc_lsb = fet_pc[0];

  assign req_hit    = line_valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);
  assign fill_match = mem_inst_ready && (mem_inst_addr == miss_pc_q);

  assign ic_busy       = (state_q != S_IDLE);
  assign ic_inst_valid = inst_valid_q;
  assign ic_inst       = inst_q;
  assign ic_inst_addr  = inst_addr_q;
  assign ic_mem_pc     = miss_pc_q;

  // The request is only offered on a cycle where the FSM will actually
  // advance to MISS_WAIT, so stalls and resets must suppress it too.
  assign ic_mem_enable = (state_q == S_MISS_REQ) && !mem_fet_busy && !flush
                         && rdy && !rst;

  always_comb begin
    state_d      = state_q;
    miss_pc_d    = miss_pc_q;
    inst_valid_d = 1'b0;
    inst_d       = '0;
    inst_addr_d  = inst_addr_q;
    fill_en      = 1'b0;

    if (flush) begin
      // Drops any request, pending miss and same-cycle fill.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fet_req) begin
            if (req_hit) begin
              inst_valid_d = 1'b1;
              inst_d       = line_data_q[req_idx];
              inst_addr_d  = fet_pc;
            end else begin
              miss_pc_d = fet_pc;
              state_d   = S_MISS_REQ;
            end
          end
        end
        S_MISS_REQ: begin
          if (!mem_fet_busy) begin
            state_d = S_MISS_WAIT;
          end
        end
        S_MISS_WAIT: begin
          // Returns for other addresses belong to other requesters.
          if (fill_match) begin
            fill_en      = 1'b1;
            inst_valid_d = 1'b1;
            inst_d       = mem_inst;
            inst_addr_d  = miss_pc_q;
            state_d      = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        state_q      <= S_IDLE;
        miss_pc_q    <= '0;
        inst_valid_q <= 1'b0;
        inst_q       <= '0;
        inst_addr_q  <= '0;
        line_valid_q <= '0;
      end else begin
        state_q      <= state_d;
        miss_pc_q    <= miss_pc_d;
        inst_valid_q <= inst_valid_d;
        inst_q       <= inst_d;
        inst_addr_q  <= inst_addr_d;
        if (fill_en) begin
          // Direct-mapped: the indexed line is simply replaced.
          line_valid_q[miss_idx] <= 1'b1;
          line_tag_q[miss_idx]   <= miss_tag;
          line_data_q[miss_idx]  <= mem_inst;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache
module tb_icache;

  typedef struct {
    logic        got;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] req_pc;
    int          lat_obs;
    int          en_cycle;
    logic        busy1;
    logic        dup;
    logic        en_viol;
  } fres_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        fet_req = 1'b0;
  logic [31:0] fet_pc = '0;
  logic        ic_busy;
  logic        ic_inst_valid;
  logic [31:0] ic_inst;
  logic [31:0] ic_inst_addr;
  logic        ic_mem_enable;
  logic [31:0] ic_mem_pc;
  logic        mem_fet_busy = 1'b0;
  logic        mem_inst_ready = 1'b0;
  logic [31:0] mem_inst = '0;
  logic [31:0] mem_inst_addr = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: per line, remember whether filled and by which full PC.
  logic        m_valid [16];
  logic [31:0] m_pc    [16];
  logic [31:0] m_word  [16];

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .fet_req(fet_req), .fet_pc(fet_pc),
    .ic_busy(ic_busy), .ic_inst_valid(ic_inst_valid), .ic_inst(ic_inst),
    .ic_inst_addr(ic_inst_addr), .ic_mem_enable(ic_mem_enable), .ic_mem_pc(ic_mem_pc),
    .mem_fet_busy(mem_fet_busy), .mem_inst_ready(mem_inst_ready),
    .mem_inst(mem_inst), .mem_inst_addr(mem_inst_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 1) % 16);
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_pc[m_idx(pc)] == pc);
  endfunction

  function automatic void m_fill(input logic [31:0] pc, input logic [31:0] w);
    m_valid[m_idx(pc)] = 1'b1;
    m_pc[m_idx(pc)]    = pc;
    m_word[m_idx(pc)]  = w;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000) return 32'h00500093;
    if (a == 32'h1002) return 32'h00004501;
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // Issue one fetch and act as the memory controller until delivery.
  task automatic fetch(input logic [31:0] pc, input int busy_cyc, input int lat,
                       output fres_t r);
    int pend, cnt, busy_left;
    logic [31:0] rpc;
    r = '{got: 1'b0, inst: '0, addr: '0, req_pc: '0, lat_obs: 0, en_cycle: 0,
          busy1: 1'b0, dup: 1'b0, en_viol: 1'b0};
    pend = 0; cnt = 0; rpc = '0; busy_left = busy_cyc;
    @(negedge clk);
    fet_req = 1'b1; fet_pc = pc;
    @(negedge clk);
    fet_req = 1'b0;
    for (int c = 1; c < 200 && !r.got; c++) begin
      mem_inst_ready = 1'b0;
      if (c == 1) r.busy1 = ic_busy;
      if (ic_inst_valid) begin
        r.got = 1'b1; r.inst = ic_inst; r.addr = ic_inst_addr; r.lat_obs = c;
      end else begin
        if (pend != 0) begin
          if (cnt == 0) begin
            mem_inst_ready = 1'b1; mem_inst_addr = rpc; mem_inst = mem_word(rpc); pend = 0;
          end else cnt--;
        end
        mem_fet_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        #1;
        if (ic_mem_enable) begin
          if (mem_fet_busy) r.en_viol = 1'b1;
          if (r.en_cycle == 0) begin
            r.en_cycle = c; r.req_pc = ic_mem_pc; pend = 1; rpc = ic_mem_pc; cnt = lat;
          end
        end
        @(negedge clk);
      end
    end
    mem_fet_busy = 1'b0;
    mem_inst_ready = 1'b0;
    @(negedge clk);
    r.dup = ic_inst_valid;
  endtask

  // Request a miss and stop at the negedge after the memory request is granted.
  task automatic start_miss(input logic [31:0] pc, output logic granted);
    granted = 1'b0;
    @(negedge clk);
    fet_req = 1'b1; fet_pc = pc;
    @(negedge clk);
    fet_req = 1'b0;
    for (int c = 0; c < 20 && !granted; c++) begin
      #1;
      if (ic_mem_enable) granted = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_clear();
    total_cnt++; if (ic_inst_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ic_inst_valid); else pass_cnt++;
    total_cnt++; if (ic_inst !== 32'h0) $display("FAIL reset_inst got %h want 0", ic_inst); else pass_cnt++;
    total_cnt++; if (ic_inst_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", ic_inst_addr); else pass_cnt++;
    total_cnt++; if (ic_mem_pc !== 32'h0) $display("FAIL reset_mem_pc got %h want 0", ic_mem_pc); else pass_cnt++;
    total_cnt++; if ({ic_busy, ic_mem_enable} !== 2'b00) $display("FAIL reset_busy_en got %b want 00", {ic_busy, ic_mem_enable}); else pass_cnt++;
  endtask

  task automatic test_cold_miss();
    fres_t r;
    fetch(32'h1000, 0, 0, r);
    total_cnt++; if (r.busy1 !== 1'b1) $display("FAIL cold_busy got %b want 1", r.busy1); else pass_cnt++;
    total_cnt++; if (r.en_cycle != 1 || r.req_pc !== 32'h1000) $display("FAIL cold_memreq got cyc=%0d pc=%h want cyc=1 pc=00001000", r.en_cycle, r.req_pc); else pass_cnt++;
    total_cnt++; if (r.got !== 1'b1 || r.inst !== 32'h00500093) $display("FAIL cold_inst got %b/%h want 1/00500093", r.got, r.inst); else pass_cnt++;
    total_cnt++; if (r.addr !== 32'h1000 || r.lat_obs != 3) $display("FAIL cold_addr_lat got %h/%0d want 00001000/3", r.addr, r.lat_obs); else pass_cnt++;
    total_cnt++; if (r.dup !== 1'b0) $display("FAIL cold_dup got %b want 0", r.dup); else pass_cnt++;
    m_fill(32'h1000, mem_word(32'h1000));
  endtask

  task automatic test_hit();
    fres_t r;
    fetch(32'h1000, 0, 0, r);
    total_cnt++; if (r.got !== 1'b1 || r.lat_obs != 1) $display("FAIL hit_latency got %b/%0d want 1/1", r.got, r.lat_obs); else pass_cnt++;
    total_cnt++; if (r.inst !== 32'h00500093 || r.addr !== 32'h1000) $display("FAIL hit_data got %h/%h want 00500093/00001000", r.inst, r.addr); else pass_cnt++;
    total_cnt++; if (r.en_cycle != 0 || r.busy1 !== 1'b0) $display("FAIL hit_no_mem got en=%0d busy=%b want 0/0", r.en_cycle, r.busy1); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    fres_t r;
    logic [31:0] pcs [4];
    pcs[0] = 32'h1000; pcs[1] = 32'h1004; pcs[2] = 32'h1008; pcs[3] = 32'h100C;
    for (int k = 1; k < 4; k++) begin
      fetch(pcs[k], 0, 1, r);
      total_cnt++; if (r.got !== 1'b1 || r.inst !== mem_word(pcs[k])) $display("FAIL b2b_fill%0d got %b/%h want 1/%h", k, r.got, r.inst, mem_word(pcs[k])); else pass_cnt++;
      m_fill(pcs[k], mem_word(pcs[k]));
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      fet_req = 1'b1; fet_pc = pcs[k];
      @(negedge clk);
      total_cnt++;
      if (ic_inst_valid !== 1'b1 || ic_inst !== m_word[m_idx(pcs[k])] || ic_inst_addr !== pcs[k] || ic_busy !== 1'b0)
        $display("FAIL b2b_hit%0d got v=%b i=%h a=%h b=%b want 1/%h/%h/0", k, ic_inst_valid, ic_inst, ic_inst_addr, ic_busy, m_word[m_idx(pcs[k])], pcs[k]);
      else pass_cnt++;
    end
    fet_req = 1'b0;
    @(negedge clk);
    total_cnt++; if (ic_inst_valid !== 1'b0 || ic_inst !== 32'h0) $display("FAIL b2b_end got %b/%h want 0/0", ic_inst_valid, ic_inst); else pass_cnt++;
  endtask

  task automatic test_conflict();
    fres_t r;
    fetch(32'h1020, 0, 0, r);
    total_cnt++; if (r.en_cycle != 1 || r.inst !== mem_word(32'h1020)) $display("FAIL conflict_fill got en=%0d i=%h want 1/%h", r.en_cycle, r.inst, mem_word(32'h1020)); else pass_cnt++;
    m_fill(32'h1020, mem_word(32'h1020));
    fetch(32'h1000, 0, 0, r);
    total_cnt++; if (r.en_cycle != 1 || r.req_pc !== 32'h1000) $display("FAIL conflict_remiss got en=%0d pc=%h want 1/00001000", r.en_cycle, r.req_pc); else pass_cnt++;
    total_cnt++; if (r.inst !== 32'h00500093) $display("FAIL conflict_inst got %h want 00500093", r.inst); else pass_cnt++;
    m_fill(32'h1000, mem_word(32'h1000));
  endtask

  task automatic test_mem_busy();
    fres_t r;
    fetch(32'h1010, 5, 1, r);
    total_cnt++; if (r.en_cycle != 6) $display("FAIL busy_en_cycle got %0d want 6", r.en_cycle); else pass_cnt++;
    total_cnt++; if (r.en_viol !== 1'b0) $display("FAIL busy_en_while_busy got %b want 0", r.en_viol); else pass_cnt++;
    total_cnt++; if (r.got !== 1'b1 || r.inst !== mem_word(32'h1010) || r.lat_obs != 9) $display("FAIL busy_deliver got %b/%h/%0d want 1/%h/9", r.got, r.inst, r.lat_obs, mem_word(32'h1010)); else pass_cnt++;
    m_fill(32'h1010, mem_word(32'h1010));
  endtask

  task automatic test_compressed();
    fres_t r;
    fetch(32'h1002, 0, 0, r);
    total_cnt++; if (r.en_cycle != 1 || r.inst !== 32'h00004501 || r.addr !== 32'h1002) $display("FAIL compressed got en=%0d i=%h a=%h want 1/00004501/00001002", r.en_cycle, r.inst, r.addr); else pass_cnt++;
    m_fill(32'h1002, 32'h00004501);
    fetch(32'h1000, 0, 0, r);
    total_cnt++; if (r.lat_obs != 1 || r.inst !== 32'h00500093) $display("FAIL compressed_distinct got lat=%0d i=%h want 1/00500093", r.lat_obs, r.inst); else pass_cnt++;
  endtask

  task automatic test_addr_mismatch();
    logic g;
    @(negedge clk);
    mem_inst_ready = 1'b1; mem_inst_addr = 32'h1016; mem_inst = mem_word(32'h1016);
    @(negedge clk);
    mem_inst_ready = 1'b0;
    total_cnt++; if (ic_inst_valid !== 1'b0) $display("FAIL idle_return got %b want 0", ic_inst_valid); else pass_cnt++;
    start_miss(32'h1016, g);
    total_cnt++; if (g !== 1'b1) $display("FAIL mismatch_grant got %b want 1", g); else pass_cnt++;
    mem_inst_ready = 1'b1; mem_inst_addr = 32'h1416; mem_inst = 32'hDEADBEEF;
    @(negedge clk);
    mem_inst_ready = 1'b0;
    total_cnt++; if (ic_inst_valid !== 1'b0 || ic_busy !== 1'b1) $display("FAIL mismatch_ignored got v=%b b=%b want 0/1", ic_inst_valid, ic_busy); else pass_cnt++;
    mem_inst_ready = 1'b1; mem_inst_addr = 32'h1016; mem_inst = mem_word(32'h1016);
    @(negedge clk);
    mem_inst_ready = 1'b0;
    total_cnt++; if (ic_inst_valid !== 1'b1 || ic_inst !== mem_word(32'h1016) || ic_inst_addr !== 32'h1016) $display("FAIL mismatch_fill got %b/%h/%h want 1/%h/00001016", ic_inst_valid, ic_inst, ic_inst_addr, mem_word(32'h1016)); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ic_inst_valid !== 1'b0 || ic_inst !== 32'h0) $display("FAIL single_pulse got %b/%h want 0/0", ic_inst_valid, ic_inst); else pass_cnt++;
    m_fill(32'h1016, mem_word(32'h1016));
  endtask

  task automatic test_flush();
    fres_t r;
    logic g;
    start_miss(32'h1018, g);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total_cnt++; if (g !== 1'b1 || ic_busy !== 1'b0 || ic_inst_valid !== 1'b0) $display("FAIL flush_wait got g=%b b=%b v=%b want 1/0/0", g, ic_busy, ic_inst_valid); else pass_cnt++;
    mem_inst_ready = 1'b1; mem_inst_addr = 32'h1018; mem_inst = mem_word(32'h1018);
    @(negedge clk);
    mem_inst_ready = 1'b0;
    total_cnt++; if (ic_inst_valid !== 1'b0) $display("FAIL flush_late_return got %b want 0", ic_inst_valid); else pass_cnt++;
    fetch(32'h1018, 0, 0, r);
    total_cnt++; if (r.en_cycle != 1 || r.inst !== mem_word(32'h1018)) $display("FAIL flush_line_invalid got en=%0d i=%h want 1/%h", r.en_cycle, r.inst, mem_word(32'h1018)); else pass_cnt++;
    m_fill(32'h1018, mem_word(32'h1018));
    start_miss(32'h101A, g);
    flush = 1'b1; mem_inst_ready = 1'b1; mem_inst_addr = 32'h101A; mem_inst = mem_word(32'h101A);
    @(negedge clk);
    flush = 1'b0; mem_inst_ready = 1'b0;
    total_cnt++; if (ic_inst_valid !== 1'b0 || ic_busy !== 1'b0) $display("FAIL flush_vs_fill got v=%b b=%b want 0/0", ic_inst_valid, ic_busy); else pass_cnt++;
    fetch(32'h101A, 0, 0, r);
    total_cnt++; if (r.en_cycle != 1) $display("FAIL flush_vs_fill_nowrite got en=%0d want 1", r.en_cycle); else pass_cnt++;
    m_fill(32'h101A, mem_word(32'h101A));
    @(negedge clk);
    fet_req = 1'b1; flush = 1'b1; fet_pc = 32'h1000;
    @(negedge clk);
    fet_req = 1'b0; flush = 1'b0;
    total_cnt++; if (ic_inst_valid !== 1'b0 || ic_busy !== 1'b0) $display("FAIL flush_drops_req got v=%b b=%b want 0/0", ic_inst_valid, ic_busy); else pass_cnt++;
  endtask

  task automatic test_rdy_hold();
    fres_t r;
    @(negedge clk);
    fet_req = 1'b1; fet_pc = 32'h1000;
    @(negedge clk);
    fet_req = 1'b0; rdy = 1'b0;
    @(negedge clk);
    total_cnt++; if (ic_inst_valid !== 1'b1 || ic_inst !== 32'h00500093) $display("FAIL rdy_hold got %b/%h want 1/00500093", ic_inst_valid, ic_inst); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (ic_inst_valid !== 1'b1 || ic_inst_addr !== 32'h1000) $display("FAIL rdy_blocks_rst got %b/%h want 1/00001000", ic_inst_valid, ic_inst_addr); else pass_cnt++;
    rst = 1'b0; rdy = 1'b1;
    @(negedge clk);
    total_cnt++; if (ic_inst_valid !== 1'b0) $display("FAIL rdy_resume got %b want 0", ic_inst_valid); else pass_cnt++;
    fetch(32'h1000, 0, 0, r);
    total_cnt++; if (r.lat_obs != 1 || r.en_cycle != 0) $display("FAIL rdy_lines_kept got lat=%0d en=%0d want 1/0", r.lat_obs, r.en_cycle); else pass_cnt++;
  endtask

  task automatic test_reset_mid_miss();
    fres_t r;
    logic g;
    start_miss(32'h101C, g);
    rst = 1'b1; mem_inst_ready = 1'b1; mem_inst_addr = 32'h101C; mem_inst = mem_word(32'h101C);
    @(negedge clk);
    rst = 1'b0; mem_inst_ready = 1'b0;
    m_clear();
    total_cnt++; if (g !== 1'b1 || ic_inst_valid !== 1'b0 || ic_busy !== 1'b0 || ic_mem_pc !== 32'h0 || ic_inst_addr !== 32'h0)
      $display("FAIL rst_mid_miss got g=%b v=%b b=%b mp=%h ia=%h want 1/0/0/0/0", g, ic_inst_valid, ic_busy, ic_mem_pc, ic_inst_addr); else pass_cnt++;
    fetch(32'h101C, 0, 0, r);
    total_cnt++; if (r.en_cycle != 1) $display("FAIL rst_no_write got en=%0d want 1", r.en_cycle); else pass_cnt++;
    m_fill(32'h101C, mem_word(32'h101C));
    fetch(32'h1000, 0, 0, r);
    total_cnt++; if (r.en_cycle != 1 || r.inst !== 32'h00500093) $display("FAIL rst_invalidates got en=%0d i=%h want 1/00500093", r.en_cycle, r.inst); else pass_cnt++;
    m_fill(32'h1000, mem_word(32'h1000));
  endtask

  task automatic test_random();
    fres_t r;
    logic [31:0] pc, exp_w;
    logic hit;
    int b, l;
    for (int i = 0; i < 40; i++) begin
      pc = 32'h1000 + ($urandom_range(0, 23) * 2) + ($urandom_range(0, 1) * 32'h40);
      b = $urandom_range(0, 3);
      l = $urandom_range(0, 3);
      hit = m_hit(pc);
      exp_w = hit ? m_word[m_idx(pc)] : mem_word(pc);
      fetch(pc, b, l, r);
      total_cnt++; if (r.got !== 1'b1 || r.inst !== exp_w || r.addr !== pc) $display("FAIL rnd%0d_data pc=%h got %b/%h/%h want 1/%h/%h", i, pc, r.got, r.inst, r.addr, exp_w, pc); else pass_cnt++;
      total_cnt++; if (r.lat_obs != (hit ? 1 : b + l + 3)) $display("FAIL rnd%0d_lat pc=%h got %0d want %0d", i, pc, r.lat_obs, hit ? 1 : b + l + 3); else pass_cnt++;
      total_cnt++; if (r.en_cycle != (hit ? 0 : b + 1) || r.en_viol !== 1'b0) $display("FAIL rnd%0d_memreq pc=%h got %0d/%b want %0d/0", i, pc, r.en_cycle, r.en_viol, hit ? 0 : b + 1); else pass_cnt++;
      total_cnt++; if (r.dup !== 1'b0) $display("FAIL rnd%0d_dup got %b want 0", i, r.dup); else pass_cnt++;
      if (!hit) m_fill(pc, mem_word(pc));
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_mem_busy();
    test_compressed();
    test_addr_mismatch();
    test_flush();
    test_rdy_hold();
    test_reset_mid_miss();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
